// File: rtl/control.sv
// control: single-cycle processor control decoder.
// The instruction decode is purely combinational from OPCODE.
// An optional sticky halt latch is enabled by defining CONTROL_HALT_LATCH_EN.
// When the latch is set, HALT is held high and every side-effecting
// strobe is suppressed until RST.
module control (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] OPCODE,
    output logic [2:0] ALU_OP,
    output logic       REG_WRITE,
    output logic       JUMP,
    output logic       MEM_OR_ALU,
    output logic       REG_OR_IM,
    output logic       MEM_WRITE,
    output logic       SET_ON,
    output logic       BNE,
    output logic       BEQ,
    output logic       HALT
);

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_HLT  = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_ADDI = 4'b0110;
    localparam logic [3:0] OP_LW   = 4'b0111;
    localparam logic [3:0] OP_SW   = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_BEQ  = 4'b1010;
    localparam logic [3:0] OP_BNE  = 4'b1011;
    localparam logic [3:0] OP_J    = 4'b1100;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    // Raw decode, before any halt masking.
    logic [2:0] dec_alu_op;
    logic       dec_reg_write;
    logic       dec_jump;
    logic       dec_mem_or_alu;
    logic       dec_reg_or_im;
    logic       dec_mem_write;
    logic       dec_set_on;
    logic       dec_bne;
    logic       dec_beq;
    logic       dec_halt;

    // Opcode decode: every output defaults to 0 so undefined opcodes act as NOP.
    always_comb begin
        dec_alu_op     = ALU_ADD;
        dec_reg_write  = 1'b0;
        dec_jump       = 1'b0;
        dec_mem_or_alu = 1'b0;
        dec_reg_or_im  = 1'b0;
        dec_mem_write  = 1'b0;
        dec_set_on     = 1'b0;
        dec_bne        = 1'b0;
        dec_beq        = 1'b0;
        dec_halt       = 1'b0;
        case (OPCODE)
            OP_NOP: ;
            OP_HLT: dec_halt = 1'b1;
            OP_ADD: begin
                dec_alu_op    = ALU_ADD;
                dec_reg_write = 1'b1;
            end
            OP_SUB: begin
                dec_alu_op    = ALU_SUB;
                dec_reg_write = 1'b1;
            end
            OP_AND: begin
                dec_alu_op    = ALU_AND;
                dec_reg_write = 1'b1;
            end
            OP_OR: begin
                dec_alu_op    = ALU_OR;
                dec_reg_write = 1'b1;
            end
            OP_ADDI: begin
                dec_alu_op    = ALU_ADD;
                dec_reg_or_im = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_LW: begin
                dec_alu_op     = ALU_ADD;
                dec_reg_or_im  = 1'b1;
                dec_mem_or_alu = 1'b1;
                dec_reg_write  = 1'b1;
            end
            OP_SW: begin
                dec_alu_op    = ALU_ADD;
                dec_reg_or_im = 1'b1;
                dec_mem_write = 1'b1;
            end
            OP_SLT: begin
                dec_alu_op    = ALU_SUB;
                dec_set_on    = 1'b1;
                dec_reg_write = 1'b1;
            end
            OP_BEQ: begin
                dec_alu_op = ALU_SUB;
                dec_beq    = 1'b1;
            end
            OP_BNE: begin
                dec_alu_op = ALU_SUB;
                dec_bne    = 1'b1;
            end
            OP_J:    dec_jump = 1'b1;
            default: ;
        endcase
    end

    // halted is high while the sticky latch holds the core stopped.
    logic halted;

`ifdef CONTROL_HALT_LATCH_EN
    logic halt_q;
    logic halt_d;

    // Latch sets on a HLT opcode and holds until reset.
    always_comb begin
        halt_d = halt_q | (OPCODE == OP_HLT);
    end

    // Reset clears the latch at once and wins over a HLT at the same edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    assign halted = halt_q;
`else
    // No state in this build: the clock and reset are intentionally unused.
    logic unused_clk_rst;
    assign unused_clk_rst = CLK ^ RST;
    assign halted         = 1'b0;
`endif

    // Output stage: the latch forces HALT and suppresses writes and control transfers.
    always_comb begin
        ALU_OP     = dec_alu_op;
        MEM_OR_ALU = dec_mem_or_alu;
        REG_OR_IM  = dec_reg_or_im;
        SET_ON     = dec_set_on;
        REG_WRITE  = dec_reg_write & ~halted;
        MEM_WRITE  = dec_mem_write & ~halted;
        JUMP       = dec_jump      & ~halted;
        BEQ        = dec_beq       & ~halted;
        BNE        = dec_bne       & ~halted;
        HALT       = dec_halt      |  halted;
    end

endmodule

// File: tb/tb_control.sv
// Directed testbench for control: a table-driven opcode sweep plus short
// hand-written sequences for the reset and halt-latch corner cases.
// Expected output words pack as {ALU_OP[2:0], REG_WRITE, JUMP, MEM_OR_ALU,
// REG_OR_IM, MEM_WRITE, SET_ON, BNE, BEQ, HALT}.
module tb_control;

    logic       CLK;
    logic       RST;
    logic [3:0] OPCODE;
    logic [2:0] ALU_OP;
    logic       REG_WRITE;
    logic       JUMP;
    logic       MEM_OR_ALU;
    logic       REG_OR_IM;
    logic       MEM_WRITE;
    logic       SET_ON;
    logic       BNE;
    logic       BEQ;
    logic       HALT;

    control dut (
        .CLK        (CLK),
        .RST        (RST),
        .OPCODE     (OPCODE),
        .ALU_OP     (ALU_OP),
        .REG_WRITE  (REG_WRITE),
        .JUMP       (JUMP),
        .MEM_OR_ALU (MEM_OR_ALU),
        .REG_OR_IM  (REG_OR_IM),
        .MEM_WRITE  (MEM_WRITE),
        .SET_ON     (SET_ON),
        .BNE        (BNE),
        .BEQ        (BEQ),
        .HALT       (HALT)
    );

    initial CLK = 1'b0;
    always #10 CLK = ~CLK;

    typedef struct {
        logic [3:0]  op;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs [16];
    int   n_pass;
    int   n_total;

    // Compare the packed DUT outputs against an expected word.
    task automatic check(input string name, input logic [11:0] exp);
        logic [11:0] got;
        got = {ALU_OP, REG_WRITE, JUMP, MEM_OR_ALU, REG_OR_IM,
               MEM_WRITE, SET_ON, BNE, BEQ, HALT};
        n_total++;
        if (got === exp) begin
            n_pass++;
            $display("ok   %-18s op=%b got=%b", name, OPCODE, got);
        end else begin
            $display("FAIL %-18s op=%b got=%b required=%b", name, OPCODE, got, exp);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;

        vecs[0]  = '{4'b0000, 12'b000_000000000};
        vecs[1]  = '{4'b0001, 12'b000_000000001};
        vecs[2]  = '{4'b0010, 12'b000_100000000};
        vecs[3]  = '{4'b0011, 12'b001_100000000};
        vecs[4]  = '{4'b0100, 12'b010_100000000};
        vecs[5]  = '{4'b0101, 12'b011_100000000};
        vecs[6]  = '{4'b0110, 12'b000_100100000};
        vecs[7]  = '{4'b0111, 12'b000_101100000};
        vecs[8]  = '{4'b1000, 12'b000_000110000};
        vecs[9]  = '{4'b1001, 12'b001_100001000};
        vecs[10] = '{4'b1010, 12'b001_000000010};
        vecs[11] = '{4'b1011, 12'b001_000000100};
        vecs[12] = '{4'b1100, 12'b000_010000000};
        vecs[13] = '{4'b1101, 12'b000_000000000};
        vecs[14] = '{4'b1110, 12'b000_000000000};
        vecs[15] = '{4'b1111, 12'b000_000000000};

        // Reset state.
        OPCODE = 4'b0000;
        RST    = 1'b1;
        #25;
        check("reset_nop", 12'b000_000000000);
        @(negedge CLK);
        RST = 1'b0;
        #2;
        check("post_reset_nop", 12'b000_000000000);

        // Opcode sweep, 50 ns per value. With the latch built in, RST stays
        // high so the HLT entry cannot set it and decode is seen under reset.
`ifdef CONTROL_HALT_LATCH_EN
        RST = 1'b1;
`endif
        for (int i = 0; i < 16; i++) begin
            OPCODE = vecs[i].op;
            #5;
            check($sformatf("sweep_%b", vecs[i].op), vecs[i].exp);
            #45;
        end
        RST = 1'b0;

        // SLT then BEQ: outputs follow the opcode with no latency.
        @(negedge CLK);
        OPCODE = 4'b1001;
        #1;
        check("slt", 12'b001_100001000);
        OPCODE = 4'b1010;
        #1;
        check("slt_to_beq", 12'b001_000000010);

        // A HLT that is gone before the clock edge never leaves HALT set.
        @(negedge CLK);
        OPCODE = 4'b0001;
        #1;
        check("hlt_comb", 12'b000_000000001);
        OPCODE = 4'b0000;
        #1;
        check("hlt_no_edge", 12'b000_000000000);

        // HLT across a rising edge, then other opcodes.
        @(negedge CLK);
        OPCODE = 4'b0001;
        @(posedge CLK);
        #1;
        OPCODE = 4'b0000;
        #1;
`ifdef CONTROL_HALT_LATCH_EN
        check("latched_nop", 12'b000_000000001);
        OPCODE = 4'b0010;
        #1;
        check("latched_add", 12'b000_000000001);
        OPCODE = 4'b0111;
        #1;
        check("latched_lw", 12'b000_001100001);
        OPCODE = 4'b1000;
        #1;
        check("latched_sw", 12'b000_000100001);
        OPCODE = 4'b1100;
        #1;
        check("latched_j", 12'b000_000000001);
        OPCODE = 4'b1011;
        #1;
        check("latched_bne", 12'b001_000000001);
        @(posedge CLK);
        #1;
        check("latched_held", 12'b001_000000001);

        // Asynchronous reset between edges releases the core at once.
        #3;
        OPCODE = 4'b0010;
        RST    = 1'b1;
        #1;
        check("async_rst_add", 12'b000_100000000);

        // Reset has priority over HLT at the same edge.
        OPCODE = 4'b0001;
        @(posedge CLK);
        #1;
        OPCODE = 4'b0000;
        RST    = 1'b0;
        #1;
        check("rst_beats_hlt", 12'b000_000000000);
        OPCODE = 4'b0010;
        #1;
        check("after_rst_add", 12'b000_100000000);
`else
        check("nolatch_nop", 12'b000_000000000);
        OPCODE = 4'b0010;
        #1;
        check("nolatch_add", 12'b000_100000000);
        @(posedge CLK);
        #1;
        OPCODE = 4'b1100;
        #1;
        check("nolatch_j", 12'b000_010000000);
        // Reset has no effect on decode in this build.
        RST = 1'b1;
        OPCODE = 4'b1000;
        #1;
        check("nolatch_rst_sw", 12'b000_000110000);
        RST = 1'b0;
`endif

        // Undefined opcodes act as NOP.
        for (int i = 13; i < 16; i++) begin
            @(negedge CLK);
            OPCODE = vecs[i].op;
            #1;
            check($sformatf("undef_%b", vecs[i].op), 12'b000_000000000);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
